// File: rtl/copper_pkg.sv
// copper_pkg: shared types and instruction-field positions for the copper
// display co-processor.
//   op_t     - 2-bit opcode held in bits [31:30] of an instruction word
//   state_t  - sequencer states
//   *_MSB/*_LSB - bit positions of the instruction fields
//   raster_reached() - WAIT release condition (unsigned 11-bit compares)
package copper_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_WAIT  = 2'b01,
    OP_RSVD  = 2'b10,
    OP_END   = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_LOAD   = 3'd3,
    ST_SEND   = 3'd4,
    ST_WAIT   = 3'd5
  } state_t;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 30;
  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 0;
  localparam int WY_MSB   = 21;
  localparam int WY_LSB   = 11;
  localparam int WX_MSB   = 10;
  localparam int WX_LSB   = 0;

  // True once the beam is at or past (wy, wx) in raster order.
  function automatic logic raster_reached(input logic [10:0] ry, input logic [10:0] rx,
                                          input logic [10:0] wy, input logic [10:0] wx);
    return (ry > wy) || ((ry == wy) && (rx >= wx));
  endfunction

endpackage

// File: rtl/copper_if.sv
// copper_if: copper write channel of the aux bus decoder.
//   copper_aux_request - write request from the copper (registered)
//   copper_aux_ack     - decoder can accept; transfer when request && ack
//   copper_aux_address - 24-bit register offset (decoder prefixes 8'hE0)
//   copper_aux_wdata   - 32-bit write data
interface copper_if;
  logic        copper_aux_request;
  logic        copper_aux_ack;
  logic [23:0] copper_aux_address;
  logic [31:0] copper_aux_wdata;

  modport master (
    output copper_aux_request,
    output copper_aux_address,
    output copper_aux_wdata,
    input  copper_aux_ack
  );

  modport slave (
    input  copper_aux_request,
    input  copper_aux_address,
    input  copper_aux_wdata,
    output copper_aux_ack
  );
endinterface

// File: rtl/copper_prog_ram.sv
// copper_prog_ram: WORDS x 32 simple dual-port program RAM.
//   clock        - system clock
//   write/waddr/wdata - load port, one word per cycle
//   raddr/rdata  - synchronous read, one cycle latency
// A read and a write to the same address in one cycle return the old word.
module copper_prog_ram #(
  parameter int WORDS = 256,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic          write,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // Load-port write.
  always_ff @(posedge clock) begin
    if (write) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; samples the array before this edge's write lands.
  always_ff @(posedge clock) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/copper.sv
// copper: display co-processor. Runs a program from internal RAM once per
// frame and issues raster-synchronised register writes on the aux bus.
//   clock, reset          - system clock, synchronous active-high reset
//   prog_write/addr/wdata - program load port
//   enable                - level; low stops the program and ignores frames
//   frame_start           - one-cycle pulse per frame
//   raster_x, raster_y    - current beam position
//   aux                   - copper write channel (master side)
//   busy                  - high whenever the sequencer is not idle
module copper
  import copper_pkg::*;
#(
  parameter  int PROG_WORDS = 256,
  localparam int PA         = $clog2(PROG_WORDS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          prog_write,
  input  logic [PA-1:0] prog_addr,
  input  logic [31:0]   prog_wdata,
  input  logic          enable,
  input  logic          frame_start,
  input  logic [10:0]   raster_x,
  input  logic [10:0]   raster_y,
  copper_if.master      aux,
  output logic          busy
);

  state_t        state, next_state;
  logic [PA-1:0] pc, pc_next;
  logic          restart, restart_next;
  logic          request;
  logic [23:0]   address;
  logic [31:0]   wdata;
  logic [10:0]   wait_y, wait_x;
  logic          latch_addr, latch_data, latch_wait;
  logic [31:0]   rdata;
  logic          start;
  op_t           op;

  // The read address always follows pc: FETCH reads the instruction and
  // DECODE (after pc++) reads the data word of a WRITE.
  copper_prog_ram #(.WORDS(PROG_WORDS), .AW(PA)) u_ram (
    .clock (clock),
    .write (prog_write),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .raddr (pc),
    .rdata (rdata)
  );

  assign start = frame_start & enable;
  assign op    = op_t'(rdata[OP_MSB:OP_LSB]);

  // Next-state, pc and latch-enable decode.
  always_comb begin
    next_state   = state;
    pc_next      = pc;
    restart_next = restart;
    latch_addr   = 1'b0;
    latch_data   = 1'b0;
    latch_wait   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_FETCH;
          pc_next    = {PA{1'b0}};
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_FETCH, ST_DECODE, ST_LOAD, ST_WAIT: begin
        if (!enable) begin
          next_state = ST_IDLE;
        end else if (start) begin
          // Restart drops anything latched but not yet on the bus.
          next_state = ST_FETCH;
          pc_next    = {PA{1'b0}};
        end else begin
          case (state)
            ST_FETCH: begin
              next_state = ST_DECODE;
              pc_next    = pc + PA'(1);
            end
            ST_DECODE: begin
              case (op)
                OP_WRITE: begin
                  latch_addr = 1'b1;
                  next_state = ST_LOAD;
                  pc_next    = pc + PA'(1);
                end
                OP_WAIT: begin
                  latch_wait = 1'b1;
                  next_state = ST_WAIT;
                end
                default: next_state = ST_IDLE;
              endcase
            end
            ST_LOAD: begin
              latch_data = 1'b1;
              next_state = ST_SEND;
            end
            ST_WAIT: begin
              if (raster_reached(raster_y, raster_x, wait_y, wait_x)) begin
                next_state = ST_FETCH;
              end else begin
                next_state = ST_WAIT;
              end
            end
            default: next_state = ST_IDLE;
          endcase
        end
      end
      ST_SEND: begin
        // A pending write always completes; frame/enable take effect after.
        if (aux.copper_aux_ack) begin
          restart_next = 1'b0;
          if (!enable) begin
            next_state = ST_IDLE;
          end else if (restart || start) begin
            next_state = ST_FETCH;
            pc_next    = {PA{1'b0}};
          end else begin
            next_state = ST_FETCH;
          end
        end else begin
          next_state = ST_SEND;
          if (start) begin
            restart_next = 1'b1;
          end else begin
            restart_next = restart;
          end
        end
      end
      default: begin
        next_state   = ST_IDLE;
        restart_next = 1'b0;
      end
    endcase
  end

  // State, pc and registered bus outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      pc      <= {PA{1'b0}};
      restart <= 1'b0;
      request <= 1'b0;
      busy    <= 1'b0;
      address <= 24'd0;
      wdata   <= 32'd0;
      wait_y  <= 11'd0;
      wait_x  <= 11'd0;
    end else begin
      state   <= next_state;
      pc      <= pc_next;
      restart <= restart_next;
      request <= (next_state == ST_SEND);
      busy    <= (next_state != ST_IDLE);
      if (latch_addr) begin
        address <= rdata[ADDR_MSB:ADDR_LSB];
      end
      if (latch_data) begin
        wdata <= rdata;
      end
      if (latch_wait) begin
        wait_y <= rdata[WY_MSB:WY_LSB];
        wait_x <= rdata[WX_MSB:WX_LSB];
      end
    end
  end

  assign aux.copper_aux_request = request;
  assign aux.copper_aux_address = address;
  assign aux.copper_aux_wdata   = wdata;

endmodule
